pipe_skid_reg: RTL and testbench

- Elastic pipeline stage: the consumer-side counterpart to the enabled data register. It decouples a producer (valid/ready writer) from a consumer (valid/ready reader) with full throughput.
- Two storage entries: main and skid. The ready returned upstream comes only from registered state, so there is no combinational path from out_ready to in_ready.
- Used between ARM datapath pipeline stages where a downstream stall must not ripple combinationally upstream.
- Includes a synchronous flush for branch/exception squash.

---
 rtl/pipe_skid_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Two-entry elastic pipeline stage (main + skid) between a
//            valid/ready producer and a valid/ready consumer. Full throughput,
//            and in_ready is decoded from registered state only, so a
//            downstream stall never reaches upstream combinationally.
//            Synchronous flush squashes all buffered entries.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   flush      in   1      synchronous squash of buffered entries
//   in_valid   in   1      producer offers in_data
//   in_ready   out  1      stage can accept this cycle (state != TWO)
//   in_data    in   WIDTH  producer payload
//   out_valid  out  1      out_data holds a valid entry (state != EMPTY)
//   out_ready  in   1      consumer takes out_data this cycle
//   out_data   out  WIDTH  head payload (main entry)
//   count      out  2      occupancy 0/1/2
// ============================================================================
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    state_t           w_state_nxt;
    logic             w_main_we;
    logic             w_main_from_skid;
    logic             w_skid_we;
    logic             w_accept;
    logic             w_pop;

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state.
    // ------------------------------------------------------------------------
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != TWO);
    assign count     = r_state;
    assign out_data  = r_main;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Next-state and register write enables.
    // Flush forces EMPTY and suppresses every write: an accept in the flush
    // cycle is dropped, a pop in the flush cycle is simply completed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_main_we        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_we        = 1'b0;

        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_we   = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        // Streaming: head leaves, new item takes its place.
                        w_main_we   = 1'b1;
                    end else if (w_accept) begin
                        // Consumer stalled: park the new item behind main.
                        w_state_nxt = TWO;
                        w_skid_we   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move state.
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_main_we        = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding; recover to a clean empty stage.
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // All storage. Payload registers are cleared only by reset; after a flush
    // their contents are stale but marked invalid by the state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_we) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_skid_we) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef COCOTB_SIM
    // Encoding 3 must never be reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_state != 2'd3)
                else $error("pipe_skid_reg: illegal state encoding");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Purpose  : Self-checking bench for pipe_skid_reg. A queue of at most two
//            items models the stage; every cycle the DUT outputs are compared
//            with the queue before the edge, and the queue is advanced with
//            the handshake rules after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_cmp;
    int n_err;

    int model_q[$];     // reference contents, head at index 0
    int pop_log[$];     // values the consumer actually received

    // stall-stability tracking
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;

    pipe_skid_reg #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs with the model, take the edge, update model.
    task automatic tick();
        bit do_pop;
        bit do_acc;
        int sz;
        sz = model_q.size();
        check("out_valid", int'(out_valid), int'(sz != 0));
        check("in_ready",  int'(in_ready),  int'(sz < 2));
        check("count",     int'(count),     sz);
        if (sz != 0) check("out_data", int'(out_data), model_q[0]);
        if (prev_stall) check("stall_stable", int'(out_data), int'(prev_data));

        do_pop = (sz != 0) && out_ready;
        do_acc = in_valid && (sz < 2);
        if (!reset && out_valid && out_ready) pop_log.push_back(int'(out_data));
        prev_stall = !reset && !flush && (sz != 0) && !out_ready;
        prev_data  = out_data;

        @(posedge clk);
        #1;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_acc) model_q.push_back(int'(in_data));
        end
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        int idx;
        int got_n;
        bit acc;

        n_cmp = 0;
        n_err = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        reset = 1'b1;
        idle_inputs();

        // ---------------- reset state ----------------
        @(posedge clk); #1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_data", int'(out_data), 0);

        // ---------------- reset mid-stream ----------------
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_valid = 1'b0;
        check("fill_count", int'(count), 2);
        reset = 1'b1; tick();
        reset = 1'b0;
        check("rst2_valid", int'(out_valid), 0);
        check("rst2_ready", int'(in_ready), 1);
        check("rst2_count", int'(count), 0);
        check("rst2_data",  int'(out_data), 0);
        in_valid = 1'b1; in_data = 8'h33; tick();
        in_valid = 1'b0;
        check("after_rst_data", int'(out_data), 8'h33);
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();

        // ---------------- streaming ----------------
        pop_log.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            tick();
            check("stream_count", int'(count), 1);
        end
        in_valid = 1'b0;
        tick(); tick();
        check("stream_n", pop_log.size(), 16);
        for (int i = 0; i < 16 && i < pop_log.size(); i++)
            check("stream_order", pop_log[i], i + 1);

        // ---------------- backpressure ----------------
        pop_log.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick(); tick();
        check("bp_count", int'(count), 2);
        check("bp_ready", int'(in_ready), 0);
        check("bp_head",  int'(out_data), 8'hA1);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && pop_log.size() < 3; k++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_n", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            check("bp_0", pop_log[0], 8'hA1);
            check("bp_1", pop_log[1], 8'hA2);
            check("bp_2", pop_log[2], 8'hA3);
        end
        tick();

        // ---------------- single-cycle stall ----------------
        pop_log.delete();
        idx = 0;
        got_n = 0;
        for (int c = 0; c < 30 && pop_log.size() < 8; c++) begin
            in_valid  = (idx < 8);
            in_data   = WIDTH'(8'h20 + idx);
            out_ready = (c != 3);
            acc = in_valid && in_ready;
            if (c == 4) check("stall_count2", int'(count), 2);
            if (c == 3) check("stall_ready", int'(in_ready), 1);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stall_n", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check("stall_order", pop_log[i], 8'h20 + i);
        tick();

        // ---------------- flush ----------------
        pop_log.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_data = 8'h66; tick();
        check("fl_count_pre", int'(count), 2);
        flush = 1'b1; in_data = 8'h77; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", int'(count), 0);
        check("fl_valid", int'(out_valid), 0);
        check("fl_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("fl_nothing_out", pop_log.size(), 0);

        // ---------------- randomized ----------------
        in_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            // Producer keeps offered data stable until it is accepted.
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = WIDTH'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(63) == 0);
            acc = (in_valid && in_ready) || flush;
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
